// File: rtl/rgb_pkg.sv
// Shared types and helpers for the palette fader: FSM state, channel maximum,
// and the reset palette pattern.
package rgb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_e;

    // All-ones value of a channel of the given width.
    function automatic int unsigned ch_max(input int unsigned ch_w);
        return (32'd1 << ch_w) - 32'd1;
    endfunction

    // Reset entry as an {R,G,B} on/off mask; entries beyond the 8 primaries are black.
    function automatic logic [2:0] default_palette(input int unsigned idx);
        return (idx < 32'd8) ? 3'(idx) : 3'b000;
    endfunction

endpackage

// File: rtl/rgb_channel_stepper.sv
// One colour channel: next value moving toward target by at most STEP, no overshoot.
module rgb_channel_stepper #(
    parameter int unsigned CH_W = 8,
    parameter int unsigned STEP = 1
) (
    input  logic [CH_W-1:0] cur_i,
    input  logic [CH_W-1:0] tgt_i,
    output logic [CH_W-1:0] nxt_c_o,
    output logic            at_tgt_c_o
);

    localparam logic [CH_W:0] STEP_W = (CH_W+1)'(STEP);

    logic          up_c;
    logic [CH_W:0] diff_c;
    logic [CH_W:0] move_c;

    // Magnitude computed with one guard bit so neither direction can wrap.
    always_comb begin
        up_c    = tgt_i > cur_i;
        diff_c  = up_c ? ({1'b0, tgt_i} - {1'b0, cur_i}) : ({1'b0, cur_i} - {1'b0, tgt_i});
        move_c  = (diff_c < STEP_W) ? diff_c : STEP_W;
        nxt_c_o = up_c ? CH_W'({1'b0, cur_i} + move_c) : CH_W'({1'b0, cur_i} - move_c);
        at_tgt_c_o = (nxt_c_o == tgt_i);
    end

endmodule

// File: rtl/rgb_palette_fader.sv
// Programmable-palette colour output with immediate load or linear fade toward
// the selected entry.
module rgb_palette_fader
    import rgb_pkg::*;
#(
    parameter int unsigned CH_W  = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned STEP  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [IDX_W-1:0]    colour,
    input  logic                fade_mode,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_data,
    output logic [3*CH_W-1:0]   rgb,
    output logic                busy,
    output logic                done
);

    localparam int unsigned   RGB_W = 3 * CH_W;
    localparam int unsigned   DEPTH = 1 << IDX_W;
    localparam logic [CH_W-1:0] MAX = CH_W'(ch_max(CH_W));

    function automatic logic [RGB_W-1:0] reset_entry(input int unsigned idx);
        logic [2:0] m;
        m = default_palette(idx);
        return {MAX & {CH_W{m[2]}}, MAX & {CH_W{m[1]}}, MAX & {CH_W{m[0]}}};
    endfunction

    logic [RGB_W-1:0] pal_q [DEPTH];
    logic [RGB_W-1:0] sel_c;

    state_e           state_q, state_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [RGB_W-1:0] tgt_q, tgt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [RGB_W-1:0] step_c;
    logic [2:0]       at_c;

    // Palette storage; reads see the pre-write contents of the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pal_q[i] <= reset_entry(i);
            end
        end else if (wr_en) begin
            pal_q[wr_idx] <= wr_data;
        end
    end

    assign sel_c = pal_q[colour];

    // Channel g occupies bits [g*CH_W +: CH_W]; g=2 is R, g=0 is B.
    for (genvar g = 0; g < 3; g++) begin : g_ch
        rgb_channel_stepper #(
            .CH_W (CH_W),
            .STEP (STEP)
        ) u_step (
            .cur_i      (rgb_q[g*CH_W +: CH_W]),
            .tgt_i      (tgt_q[g*CH_W +: CH_W]),
            .nxt_c_o    (step_c[g*CH_W +: CH_W]),
            .at_tgt_c_o (at_c[g])
        );
    end

    always_comb begin
        state_d = state_q;
        rgb_d   = rgb_q;
        tgt_d   = tgt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (!fade_mode) begin
                        rgb_d  = sel_c;
                        done_d = 1'b1;
                    end else if (sel_c == rgb_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = sel_c;
                        state_d = FADE;
                        busy_d  = 1'b1;
                    end
                end
            end
            FADE: begin
                rgb_d = step_c;
                if (&at_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rgb_q   <= '0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rgb_q   <= rgb_d;
            tgt_q   <= tgt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rgb  = rgb_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rgb_palette_fader.sv
// Directed bench for rgb_palette_fader: STEP=51 instance driven from a vector
// table, STEP=100 instance sharing the stimulus for the downward fade.
module tb_rgb_palette_fader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  colour;
    logic        fade_mode;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [23:0] wr_data;
    logic [23:0] rgb_a, rgb_b;
    logic        busy_a, busy_b, done_a, done_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rgb_palette_fader #(.CH_W(8), .IDX_W(3), .STEP(51)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour), .fade_mode(fade_mode),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rgb(rgb_a), .busy(busy_a), .done(done_a)
    );

    rgb_palette_fader #(.CH_W(8), .IDX_W(3), .STEP(100)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour), .fade_mode(fade_mode),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rgb(rgb_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic        en;
        logic [2:0]  col;
        logic        fm;
        logic        we;
        logic [2:0]  widx;
        logic [23:0] wdat;
        logic [23:0] e_rgb;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic [2:0] col, input logic fm,
                                input logic we, input logic [2:0] widx, input logic [23:0] wdat,
                                input logic [23:0] r, input logic b, input logic d);
        vec_t v;
        v.en = en; v.col = col; v.fm = fm; v.we = we; v.widx = widx; v.wdat = wdat;
        v.e_rgb = r; v.e_busy = b; v.e_done = d;
        return v;
    endfunction

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] col, input logic fm,
                         input logic we, input logic [2:0] widx, input logic [23:0] wdat);
        @(negedge clk);
        enable = en; colour = col; fade_mode = fm;
        wr_en = we; wr_idx = widx; wr_data = wdat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; colour = '0; fade_mode = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0;

        // Immediate load and hold sweep
        tbl.push_back(mk(1, 3'd5, 0, 0, 0, 24'h0, 24'hFF00FF, 0, 1));
        for (int c = 0; c < 8; c++)
            tbl.push_back(mk(0, 3'(c), 0, 0, 0, 24'h0, 24'hFF00FF, 0, 0));
        // Fade 0 -> white with enable pulses mid-fade
        tbl.push_back(mk(1, 3'd0, 0, 0, 0, 24'h0, 24'h000000, 0, 1));
        tbl.push_back(mk(1, 3'd7, 1, 0, 0, 24'h0, 24'h000000, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 0, 24'h0, 24'h333333, 1, 0));
        tbl.push_back(mk(1, 3'd3, 0, 0, 0, 24'h0, 24'h666666, 1, 0));
        tbl.push_back(mk(1, 3'd0, 1, 0, 0, 24'h0, 24'h999999, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 0, 24'h0, 24'hCCCCCC, 1, 0));
        tbl.push_back(mk(1, 3'd2, 0, 0, 0, 24'h0, 24'hFFFFFF, 0, 1));
        tbl.push_back(mk(0, 3'd0, 0, 0, 0, 24'h0, 24'hFFFFFF, 0, 0));
        // Non-multiple fade, then read-before-write on the same index
        tbl.push_back(mk(0, 3'd0, 0, 1, 3'd2, 24'h640A00, 24'hFFFFFF, 0, 0));
        tbl.push_back(mk(1, 3'd0, 0, 0, 0, 24'h0, 24'h000000, 0, 1));
        tbl.push_back(mk(1, 3'd2, 1, 0, 0, 24'h0, 24'h000000, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 0, 24'h0, 24'h330A00, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 0, 24'h0, 24'h640A00, 0, 1));
        tbl.push_back(mk(1, 3'd0, 0, 0, 0, 24'h0, 24'h000000, 0, 1));
        tbl.push_back(mk(1, 3'd2, 0, 1, 3'd2, 24'h123456, 24'h640A00, 0, 1));
        tbl.push_back(mk(1, 3'd2, 0, 0, 0, 24'h0, 24'h123456, 0, 1));
        // Fade request to the colour already shown: done only, no busy
        tbl.push_back(mk(1, 3'd2, 1, 0, 0, 24'h0, 24'h123456, 0, 1));
        tbl.push_back(mk(0, 3'd2, 0, 0, 0, 24'h0, 24'h123456, 0, 0));

        #3;
        check("reset_rgb", rgb_a, 24'h0);
        check("reset_busy", 24'(busy_a), 24'h0);
        check("reset_done", 24'(done_a), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].col, tbl[i].fm, tbl[i].we, tbl[i].widx, tbl[i].wdat);
            check($sformatf("vec%0d_rgb", i), rgb_a, tbl[i].e_rgb);
            check($sformatf("vec%0d_busy", i), 24'(busy_a), 24'(tbl[i].e_busy));
            check($sformatf("vec%0d_done", i), 24'(done_a), 24'(tbl[i].e_done));
        end

        // Downward fade on the STEP=100 instance; palette[0] rewritten mid-fade
        drive(1, 3'd7, 0, 0, 0, 24'h0);
        check("down_load_b", rgb_b, 24'hFFFFFF);
        drive(1, 3'd0, 1, 0, 0, 24'h0);
        check("down_start_rgb", rgb_b, 24'hFFFFFF);
        check("down_start_busy", 24'(busy_b), 24'h1);
        drive(0, 3'd0, 0, 1, 3'd0, 24'h111111);
        check("down_1_rgb", rgb_b, 24'h9B9B9B);
        drive(0, 3'd5, 1, 0, 0, 24'h0);
        check("down_2_rgb", rgb_b, 24'h373737);
        check("down_2_done", 24'(done_b), 24'h0);
        drive(0, 3'd0, 0, 0, 0, 24'h0);
        check("down_3_rgb", rgb_b, 24'h000000);
        check("down_3_busy", 24'(busy_b), 24'h0);
        check("down_3_done", 24'(done_b), 24'h1);
        for (int k = 0; k < 3; k++) drive(0, 3'd0, 0, 0, 0, 24'h0);
        check("down_a_final", rgb_a, 24'h000000);
        check("down_a_busy", 24'(busy_a), 24'h0);

        // Async reset in the middle of a fade
        drive(1, 3'd7, 1, 0, 0, 24'h0);
        check("rst_fade_busy", 24'(busy_a), 24'h1);
        drive(0, 3'd0, 0, 0, 0, 24'h0);
        drive(0, 3'd0, 0, 0, 0, 24'h0);
        check("rst_pre_rgb", rgb_a, 24'h666666);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_rgb", rgb_a, 24'h0);
        check("rst_async_busy", 24'(busy_a), 24'h0);
        check("rst_async_done", 24'(done_a), 24'h0);
        check("rst_async_rgb_b", rgb_b, 24'h0);
        @(posedge clk);
        #1;
        check("rst_hold_done", 24'(done_a), 24'h0);
        check("rst_hold_busy", 24'(busy_a), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 3'd2, 0, 0, 0, 24'h0);
        check("rst_pal2_rgb", rgb_a, 24'h00FF00);
        check("rst_pal2_done", 24'(done_a), 24'h1);
        drive(1, 3'd0, 0, 0, 0, 24'h0);
        check("rst_pal0_rgb_b", rgb_b, 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_palette_fader.md
Name: rgb_palette_fader

Overview:
Parametrised successor to the 3-bit colour-to-RGB converter. It adds a programmable palette of 2^IDX_W entries, configurable channel width, and an optional linear fade mode. In fade mode the output ramps toward the selected colour by a fixed step per clock rather than jumping. It sits between the colour-select logic and the LED/display driver.

Parameters:
CH_W, 8, bits per colour channel; rgb is 3*CH_W wide, packed {R,G,B}
IDX_W, 3, palette index width; palette depth = 2^IDX_W, IDX_W >= 3
STEP, 1, per-cycle channel increment in fade mode; legal range 1 .. 2^CH_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  request: load/fade to palette[colour]
colour  in  IDX_W  palette index select
fade_mode  in  1  0 = immediate load, 1 = linear fade; sampled only when a request is accepted
wr_en  in  1  palette write strobe
wr_idx  in  IDX_W  palette write index
wr_data  in  3*CH_W  palette write data {R,G,B}
rgb  out  3*CH_W  registered colour output
busy  out  1  high while a fade is in progress
done  out  1  one-cycle pulse when rgb reaches the accepted target

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values (immediate on rst_n low): rgb=0, busy=0, done=0, state=IDLE. Palette entry i for i<8 = {i[2]?MAX:0, i[1]?MAX:0, i[0]?MAX:0}, where MAX = 2^CH_W-1; entries i>=8 = 0.
- States: IDLE, FADE.
- Request acceptance: a request is accepted only when enable=1 and state=IDLE. enable is ignored in FADE.
- Accepted with fade_mode=0: rgb <= palette[colour] at that edge (1-cycle latency); done=1 for the next cycle; stays IDLE.
- Accepted with fade_mode=1:
  - If palette[colour]==rgb: done pulse, stay IDLE.
  - Otherwise: latch target, go to FADE, busy=1 from the next cycle.
- In FADE, every cycle, each channel independently moves toward its target: c <= c +/- min(STEP, |target-c|). No overshoot; a channel already at target holds.
- When all three channels equal target after an update: rgb==target, done=1 and busy=0 in that same cycle, return to IDLE.
- Fade length is ceil(max channel |diff| / STEP) cycles.
- enable=0 in IDLE: rgb holds its value indefinitely.
- Palette writes:
  - wr_en=1 writes palette[wr_idx] at the edge. Writes are permitted in any state.
  - A same-cycle read of the same index sees the OLD data (read-before-write).
  - A write to the entry being faded to does not alter the latched target.
- fade_mode or colour changes during FADE have no effect on the fade in progress.
- Arithmetic is unsigned and width-safe: difference and step are computed in CH_W+1 bits; no wrap at 0 or MAX.
- Async reset mid-fade: outputs and palette return to reset values immediately; no done pulse.

Decomposition:
- Package rgb_pkg:
  - state enum {IDLE, FADE}
  - localparam for channel MAX
  - function default_palette(idx) returning the reset entry
  - helper to pack/unpack {R,G,B}
- Sub-module rgb_channel_stepper (CH_W, STEP):
  - combinational next-value for one channel given current value and target, plus an at_target flag
  - instantiated three times
- Top holds the palette array, FSM, and output registers.

Test Plan:
1. Immediate mode, defaults (CH_W=8): after reset rgb=0. colour=3'b101, enable=1 for one cycle -> rgb=24'hFF00FF next cycle, done pulses once, busy stays 0.
2. Hold: enable=0, sweep colour 0..7 -> rgb unchanged at 24'hFF00FF, done stays 0.
3. Fade with STEP=51, from rgb=0, colour=7, fade_mode=1 -> rgb steps 333333, 666666, 999999, CCCCCC, FFFFFF over 5 cycles. busy high for the first 4 of those cycles; done=1 in the cycle rgb=FFFFFF. enable pulses mid-fade are ignored.
4. Non-multiple fade with STEP=51: write palette[2]=24'h640A00, then fade from 0 -> 330A00 then 640A00 (2 cycles, no overshoot). Same-cycle write and select of index 2 with new data 0x123456 -> old 640A00 loaded.
5. Downward fade: from FFFFFF to palette[0]=000000 with STEP=100 -> 9B9B9B, 373737, 000000, done on the third cycle.
6. Assert rst_n low mid-fade (async, between edges) -> rgb=0 and busy=0 immediately. Palette[2] reads back the default 00FF00. No done pulse.
